// File: rtl/strobe_period_meter.sv
// strobe_period_meter: measures clk_i cycles between successive rising edges of
// an (optionally asynchronous) strobe and presents each interval on valid/ready.
module strobe_period_meter #(
   parameter int COUNTER_WIDTH = 16,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                     clk_i,
   input  logic                     a_rst_n_i,
   input  logic                     enable_i,
   input  logic                     strobe_i,
   output logic [COUNTER_WIDTH-1:0] period_o,
   output logic                     overflow_o,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic                     lost_o,
   input  logic                     clear_lost_i
);
   localparam logic [COUNTER_WIDTH-1:0] MAX = '1;
   typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
   state_t                   state, state_nxt;
   logic [SYNC_STAGES-1:0]   sync;
   logic                     dly, rise_q, emit, emit_ovf, res_vld, res_ovf, drop;
   logic [COUNTER_WIDTH-1:0] cnt, cnt_nxt, res_period;
   assign drop = res_vld & valid_o & ~ready_i;
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      emit      = 1'b0;
      emit_ovf  = 1'b0;
      if (!enable_i) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = ARM;
               cnt_nxt   = '0;
            end
            ARM: if (rise_q) begin
               state_nxt = MEASURE;
               cnt_nxt   = COUNTER_WIDTH'(1);
            end
            MEASURE: begin
               emit      = rise_q | (cnt == MAX);
               emit_ovf  = ~rise_q & (cnt == MAX);
               cnt_nxt   = rise_q ? COUNTER_WIDTH'(1) : emit_ovf ? '0 : cnt + 1'b1;
               state_nxt = emit_ovf ? ARM : MEASURE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end
   // Edge is registered and the result staged once so valid_o follows the
   // sampling edge by SYNC_STAGES+2 cycles.
   always_ff @(posedge clk_i or negedge a_rst_n_i) begin
      if (!a_rst_n_i) begin
         sync       <= '0;
         dly        <= 1'b0;
         rise_q     <= 1'b0;
         state      <= IDLE;
         cnt        <= '0;
         res_vld    <= 1'b0;
         res_ovf    <= 1'b0;
         res_period <= '0;
         period_o   <= '0;
         overflow_o <= 1'b0;
         valid_o    <= 1'b0;
         lost_o     <= 1'b0;
      end else begin
         sync       <= {sync[SYNC_STAGES-2:0], strobe_i};
         dly        <= sync[SYNC_STAGES-1];
         rise_q     <= sync[SYNC_STAGES-1] & ~dly;
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         res_vld    <= emit;
         res_ovf    <= emit_ovf;
         res_period <= cnt;
         if (res_vld && !drop) begin
            period_o   <= res_period;
            overflow_o <= res_ovf;
            valid_o    <= 1'b1;
         end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
         end
         lost_o <= drop | (lost_o & ~clear_lost_i);
      end
   end
endmodule

// File: tb/tb_strobe_period_meter.sv
// tb_strobe_period_meter: randomized and directed strobe patterns; expected
// intervals come from edge timestamps and are checked by a decoupled monitor.
module tb_strobe_period_meter;
   localparam int W = 4, S = 2, MAX = 15;
   logic clk = 0, rst_n = 0, enable = 0, strobe = 0, ready = 0, clear_lost = 0;
   logic [W-1:0] period;
   logic overflow, valid, lost;
   int n_chk = 0, n_fail = 0, cyc = 0, last = 0;
   bit armed = 0, prev = 0, rand_ready = 0;
   logic [W:0] q[$];
   logic [W:0] e;

   strobe_period_meter #(.COUNTER_WIDTH(W), .SYNC_STAGES(S)) dut (
      .clk_i(clk), .a_rst_n_i(rst_n), .enable_i(enable), .strobe_i(strobe),
      .period_o(period), .overflow_o(overflow), .valid_o(valid), .ready_i(ready),
      .lost_o(lost), .clear_lost_i(clear_lost));

   always #5 clk = ~clk;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: timestamps of rising edges in sampled strobe; an armed interval
   // reaching MAX samples without an edge reports MAX with overflow and disarms.
   function automatic void model(bit s, bit en);
      int gap;
      cyc++;
      gap = cyc - last;
      if (!en) armed = 0;
      else if (s && !prev) begin
         if (armed) q.push_back({1'b0, W'(gap)});
         armed = 1;
         last  = cyc;
      end else if (armed && gap == MAX) begin
         q.push_back({1'b1, W'(MAX)});
         armed = 0;
      end
      prev = s;
   endfunction

   task automatic tick();
      bit s, en;
      s  = strobe;
      en = enable;
      @(posedge clk);
      #1;
      model(s, en);
   endtask

   task automatic pulse(int gap, int hi);
      strobe = 1;
      repeat (hi) tick();
      strobe = 0;
      repeat (gap - hi) tick();
   endtask

   task automatic drain();
      int t = 0;
      repeat (25) tick();
      while (q.size() != 0 && t < 30) begin
         tick();
         t++;
      end
      chk("drain_queue_empty", q.size(), 0);
   endtask

   initial forever begin
      @(posedge clk);
      #2;
      if (rand_ready) ready = ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   always @(negedge clk) begin
      if (rst_n && valid && ready) begin
         if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_result: got period %0d overflow %0d, expected none", period, overflow);
         end else begin
            e = q.pop_front();
            chk("period", 32'(period), 32'(e[W-1:0]));
            chk("overflow", 32'(overflow), 32'(e[W]));
         end
         chk("lost_clear", 32'(lost), 0);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", 32'(valid), 0);
      chk("reset_period", 32'(period), 0);
      chk("reset_overflow", 32'(overflow), 0);
      chk("reset_lost", 32'(lost), 0);
      @(negedge clk);
      rst_n = 1;
      enable = 1;
      ready = 1;
      repeat (3) tick();
      // period 10 with ready held high, plus latency of valid_o
      pulse(10, 1);
      strobe = 1;
      tick();
      strobe = 0;
      repeat (S + 1) tick();
      @(negedge clk);
      chk("latency_before", 32'(valid), 0);
      tick();
      @(negedge clk);
      chk("latency_valid", 32'(valid), 1);
      chk("latency_period", 32'(period), 10);
      repeat (10 - S - 3) tick();
      repeat (3) pulse(10, 1);
      drain();
      // period change 5 -> 7 with random backpressure
      rand_ready = 1;
      repeat (6) pulse(5, 2);
      pulse(9, 4);
      repeat (6) pulse(7, 3);
      drain();
      chk("no_loss_rate_change", 32'(lost), 0);
      // strobe stops -> saturated overflow result
      rand_ready = 0;
      ready = 0;
      strobe = 1;
      tick();
      strobe = 0;
      repeat (20) tick();
      @(negedge clk);
      chk("ovf_valid", 32'(valid), 1);
      chk("ovf_period", 32'(period), MAX);
      chk("ovf_flag", 32'(overflow), 1);
      ready = 1;
      rand_ready = 1;
      pulse(7, 2);
      pulse(7, 2);
      pulse(3, 1);
      drain();
      // continuously high strobe ends in overflow
      pulse(6, 1);
      strobe = 1;
      repeat (30) tick();
      strobe = 0;
      drain();
      // randomized intervals, including ones beyond MAX
      for (int i = 0; i < 120; i++) begin
         int g;
         g = $urandom_range(2, 18);
         pulse(g, $urandom_range(1, g - 1));
      end
      drain();
      // backpressure: hold, drop, clear, then emit coinciding with handshake
      rand_ready = 0;
      ready = 0;
      pulse(6, 1);
      pulse(8, 1);
      strobe = 1;
      tick();
      strobe = 0;
      repeat (5) tick();
      @(negedge clk);
      chk("hold_valid", 32'(valid), 1);
      chk("hold_period", 32'(period), 6);
      chk("hold_overflow", 32'(overflow), 0);
      chk("drop_lost", 32'(lost), 1);
      if (q.size() > 1) q.delete(1);
      clear_lost = 1;
      tick();
      clear_lost = 0;
      @(negedge clk);
      chk("lost_cleared", 32'(lost), 0);
      repeat (3) tick();
      strobe = 1;
      tick();
      strobe = 0;
      repeat (S + 1) tick();
      @(negedge clk);
      chk("still_held_period", 32'(period), 6);
      ready = 1;
      tick();
      @(negedge clk);
      chk("no_bubble_valid", 32'(valid), 1);
      chk("no_bubble_period", 32'(period), 10);
      rand_ready = 1;
      drain();
      // enable dropped mid-interval discards it; re-arm needed afterwards
      pulse(10, 1);
      pulse(6, 1);
      strobe = 1;
      tick();
      strobe = 0;
      repeat (5) tick();
      enable = 0;
      repeat (3) tick();
      pulse(5, 1);
      repeat (10) tick();
      @(negedge clk);
      chk("disabled_no_valid", 32'(valid), 0);
      chk("disabled_queue", q.size(), 0);
      enable = 1;
      tick();
      pulse(4, 1);
      pulse(8, 3);
      pulse(3, 1);
      drain();
      // asynchronous reset while a result is held
      rand_ready = 0;
      ready = 0;
      pulse(5, 1);
      pulse(9, 1);
      @(negedge clk);
      chk("pre_reset_valid", 32'(valid), 1);
      @(posedge clk);
      #2;
      rst_n = 0;
      #1;
      chk("async_valid", 32'(valid), 0);
      chk("async_period", 32'(period), 0);
      chk("async_overflow", 32'(overflow), 0);
      chk("async_lost", 32'(lost), 0);
      q.delete();
      armed = 0;
      prev = 0;
      @(negedge clk);
      rst_n = 1;
      rand_ready = 1;
      pulse(9, 2);
      pulse(9, 2);
      pulse(4, 1);
      drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
